rx_stream_arbiter: RTL and testbench

- Merges the two modem receive word streams (sub-GHz "09" and 2.4 GHz "24") into the single shared receive FIFO.
- Both channels arrive in the same modem DDR clock domain. Each channel's 32-bit I/Q words sit in a one-word holding buffer and are pushed to the FIFO under round-robin arbitration.
- Mode changes are sequenced so that no partial interleave or stale word leaks across a reconfiguration.
- Sits between the two LVDS receiver instances and the FIFO write port.

---
 rtl/rx_stream_pkg.sv | 25 ++
 rtl/rx_chan_buf.sv | 74 +++++++
 rtl/rx_stream_arbiter.sv | 150 +++++++++++++++
 tb/tb_rx_stream_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_stream_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rx_stream_pkg : shared encodings for the dual-channel RX arbiter    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package rx_stream_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_09   = 2'b01,
    MODE_24   = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam int CH_09 = 0;
  localparam int CH_24 = 1;

endpackage
`default_nettype wire

// File: rtl/rx_chan_buf.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rx_chan_buf : one-word holding buffer with sticky drop flag/counter |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module rx_chan_buf
  import rx_stream_pkg::*;
#(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  accept_i,
  input  logic                  push_i,
  input  logic [31:0]           data_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic                  full_o,
  output logic [31:0]           data_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  logic                  full_q, full_d;
  logic [31:0]           data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  capture;
  logic                  drop;

  // A word arriving while the buffer is being popped refills it instead of dropping.
  assign capture = accept_i & push_i & (~full_q | pop_i);
  assign drop    = accept_i & push_i & full_q & ~pop_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ovf_d  = clear_i ? 1'b0 : ovf_q;
    cnt_d  = clear_i ? '0 : cnt_q;
    if (capture) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (cnt_d != '1) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full_o     = full_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/rx_stream_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rx_stream_arbiter : round-robin merge of ch09/ch24 RX words to FIFO |
// | Optional macro RX_STREAM_ARB_CH_TAG_EN tags bit31 with the source.  |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module rx_stream_arbiter
  import rx_stream_pkg::*;
#(
  parameter int DROP_CNT_W  = 16,
  parameter bit CH_09_FIRST = 1'b1
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_mode,
  input  logic                  i_push_09,
  input  logic [31:0]           i_data_09,
  input  logic                  i_push_24,
  input  logic [31:0]           i_data_24,
  input  logic                  i_fifo_full,
  input  logic                  i_clear_status,
  output logic                  o_fifo_push,
  output logic [31:0]           o_fifo_data,
  output logic [1:0]            o_active_mode,
  output logic [1:0]            o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_cnt_09,
  output logic [DROP_CNT_W-1:0] o_drop_cnt_24,
  output logic [1:0]            o_state
);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic        ptr_q, ptr_d;      // channel that wins the next tie
  logic        push_q, push_d;
  logic [31:0] data_q, data_d;

  logic [1:0]  accept;
  logic [1:0]  full;
  logic [1:0]  pop;
  logic [31:0] buf_09, buf_24;
  logic        grant;
  logic        sel;
  logic [31:0] word;

  // Mode bit n enables channel n, so the active mode doubles as the accept mask.
  assign accept = (state_q == ST_RUN) ? mode_q : 2'b00;

  rx_chan_buf #(.DROP_CNT_W(DROP_CNT_W)) u_buf_09 (
    .clk_i      (i_ddr_clk),
    .rst_i      (i_reset),
    .accept_i   (accept[CH_09]),
    .push_i     (i_push_09),
    .data_i     (i_data_09),
    .pop_i      (pop[CH_09]),
    .clear_i    (i_clear_status),
    .full_o     (full[CH_09]),
    .data_o     (buf_09),
    .overflow_o (o_overflow[CH_09]),
    .drop_cnt_o (o_drop_cnt_09)
  );

  rx_chan_buf #(.DROP_CNT_W(DROP_CNT_W)) u_buf_24 (
    .clk_i      (i_ddr_clk),
    .rst_i      (i_reset),
    .accept_i   (accept[CH_24]),
    .push_i     (i_push_24),
    .data_i     (i_data_24),
    .pop_i      (pop[CH_24]),
    .clear_i    (i_clear_status),
    .full_o     (full[CH_24]),
    .data_o     (buf_24),
    .overflow_o (o_overflow[CH_24]),
    .drop_cnt_o (o_drop_cnt_24)
  );

  always_comb begin
    grant = 1'b0;
    sel   = ptr_q;
    ptr_d = ptr_q;
    if (!i_fifo_full) begin
      if (&full) begin
        grant = 1'b1;
        sel   = ptr_q;
        ptr_d = ~ptr_q;
      end else if (full[CH_09]) begin
        grant = 1'b1;
        sel   = 1'b0;
      end else if (full[CH_24]) begin
        grant = 1'b1;
        sel   = 1'b1;
      end
    end
    pop  = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
    word = sel ? buf_24 : buf_09;
`ifdef RX_STREAM_ARB_CH_TAG_EN
    word[31] = sel;
`endif
    push_d = grant;
    data_d = grant ? word : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (i_mode != MODE_OFF) begin
          state_d = ST_RUN;
          mode_d  = i_mode;
        end
      end
      ST_RUN: begin
        if (i_mode != mode_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((full == 2'b00) && !push_q) begin
          state_d = ST_IDLE;
          mode_d  = MODE_OFF;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mode_d  = MODE_OFF;
      end
    endcase
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      ptr_q   <= ~CH_09_FIRST;
      push_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ptr_q   <= ptr_d;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end

  assign o_fifo_push   = push_q;
  assign o_fifo_data   = data_q;
  assign o_active_mode = mode_q;
  assign o_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_stream_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_rx_stream_arbiter : scoreboard bench for rx_stream_arbiter       |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_rx_stream_arbiter;

  localparam int CNT_W = 4;

  logic             i_ddr_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic [1:0]       i_mode = 2'b00;
  logic             i_push_09 = 1'b0;
  logic [31:0]      i_data_09 = 32'h0;
  logic             i_push_24 = 1'b0;
  logic [31:0]      i_data_24 = 32'h0;
  logic             i_fifo_full = 1'b0;
  logic             i_clear_status = 1'b0;
  logic             o_fifo_push;
  logic [31:0]      o_fifo_data;
  logic [1:0]       o_active_mode;
  logic [1:0]       o_overflow;
  logic [CNT_W-1:0] o_drop_cnt_09;
  logic [CNT_W-1:0] o_drop_cnt_24;
  logic [1:0]       o_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];

  rx_stream_arbiter #(.DROP_CNT_W(CNT_W), .CH_09_FIRST(1'b1)) dut (
    .i_ddr_clk      (i_ddr_clk),
    .i_reset        (i_reset),
    .i_mode         (i_mode),
    .i_push_09      (i_push_09),
    .i_data_09      (i_data_09),
    .i_push_24      (i_push_24),
    .i_data_24      (i_data_24),
    .i_fifo_full    (i_fifo_full),
    .i_clear_status (i_clear_status),
    .o_fifo_push    (o_fifo_push),
    .o_fifo_data    (o_fifo_data),
    .o_active_mode  (o_active_mode),
    .o_overflow     (o_overflow),
    .o_drop_cnt_09  (o_drop_cnt_09),
    .o_drop_cnt_24  (o_drop_cnt_24),
    .o_state        (o_state)
  );

  always #5 i_ddr_clk = ~i_ddr_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tag_word(input logic ch, input logic [31:0] d);
    logic [31:0] r;
    r = d;
`ifdef RX_STREAM_ARB_CH_TAG_EN
    r[31] = ch;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge i_ddr_clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] st, input logic [1:0] md, input string tag);
    for (int n = 0; n < 40; n++) begin
      if (o_state == st && o_active_mode == md) break;
      tick();
    end
    check_eq(tag, {o_state, o_active_mode}, {st, md});
  endtask

  task automatic drive(input logic p09, input logic [31:0] d09,
                       input logic p24, input logic [31:0] d24);
    i_push_09 = p09;
    i_data_09 = d09;
    i_push_24 = p24;
    i_data_24 = d24;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_push"},  o_fifo_push,   0);
    check_eq({tag, "_data"},  o_fifo_data,   0);
    check_eq({tag, "_mode"},  o_active_mode, 0);
    check_eq({tag, "_ovf"},   o_overflow,    0);
    check_eq({tag, "_cnt09"}, o_drop_cnt_09, 0);
    check_eq({tag, "_cnt24"}, o_drop_cnt_24, 0);
    check_eq({tag, "_state"}, o_state,       0);
  endtask

  // Every FIFO write is matched against the next expected word in order.
  always @(negedge i_ddr_clk) begin
    if (!i_reset && o_fifo_push) begin
      if (sb.size() == 0) check_eq("unexpected_push", o_fifo_data, 32'hxxxx_xxxx);
      else check_eq("fifo_data", o_fifo_data, sb.pop_front());
    end
  end

  initial begin
    repeat (3) tick();
    check_zero("reset");
    i_reset = 1'b0;

    // Single channel, latency, disabled channel ignored
    i_mode = 2'b01;
    wait_state(2'b01, 2'b01, "run_09");
    drive(1, 32'hA5A5_0001, 1, 32'hDEAD_0024);
    sb.push_back(tag_word(0, 32'hA5A5_0001));
    tick();
    drive(0, 0, 0, 0);
    check_eq("lat_edge_k", o_fifo_push, 0);
    tick();
    check_eq("lat_edge_k1", o_fifo_push, 1);
    check_eq("ign24_cnt", o_drop_cnt_24, 0);
    check_eq("ign24_ovf", o_overflow, 0);

    // Interleave with round-robin pointer
    i_mode = 2'b11;
    wait_state(2'b01, 2'b11, "run_both");
    drive(1, 32'h1111_1111, 1, 32'h2222_2222);
    sb.push_back(tag_word(0, 32'h1111_1111));
    sb.push_back(tag_word(1, 32'h2222_2222));
    tick();
    drive(0, 0, 0, 0);
    repeat (2) tick();
    drive(1, 32'h3333_3333, 1, 32'h4444_4444);
    sb.push_back(tag_word(1, 32'h4444_4444));
    sb.push_back(tag_word(0, 32'h3333_3333));
    tick();
    drive(0, 0, 0, 0);
    repeat (3) tick();

    // FIFO full: first word held, later words dropped
    i_mode = 2'b01;
    wait_state(2'b01, 2'b01, "run_09b");
    i_fifo_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 16 == 0) begin
        drive(1, 32'h0B00_0000 + i, 0, 0);
        if (i == 0) sb.push_back(tag_word(0, 32'h0B00_0000));
      end
      tick();
      drive(0, 0, 0, 0);
    end
    i_fifo_full = 1'b0;
    repeat (2) tick();
    check_eq("full_cnt09", o_drop_cnt_09, 2);
    check_eq("full_ovf", o_overflow, 2'b01);
    i_clear_status = 1'b1;
    tick();
    i_clear_status = 1'b0;
    check_eq("clr_cnt09", o_drop_cnt_09, 0);
    check_eq("clr_ovf", o_overflow, 0);

    // Reconfiguration drain with FIFO full
    i_mode = 2'b11;
    wait_state(2'b01, 2'b11, "run_both2");
    i_fifo_full = 1'b1;
    drive(1, 32'h5555_5555, 1, 32'h6666_6666);
    sb.push_back(tag_word(0, 32'h5555_5555));
    sb.push_back(tag_word(1, 32'h6666_6666));
    tick();
    drive(0, 0, 0, 0);
    i_mode = 2'b10;
    tick();
    drive(1, 32'h7777_7777, 1, 32'h0888_8888);
    tick();
    drive(0, 0, 0, 0);
    repeat (3) tick();
    check_eq("drain_state", o_state, 2'b10);
    check_eq("drain_mode", o_active_mode, 2'b11);
    check_eq("drain_nodrop", {o_drop_cnt_09, o_drop_cnt_24}, 0);
    i_fifo_full = 1'b0;
    wait_state(2'b00, 2'b00, "drain_idle");
    tick();
    check_eq("drain_run", {o_state, o_active_mode}, {2'b01, 2'b10});
    drive(1, 32'h0999_9999, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    repeat (2) tick();
    check_eq("dis09_cnt", o_drop_cnt_09, 0);
    check_eq("dis09_ovf", o_overflow, 0);

    // Counter saturation on ch24
    i_fifo_full = 1'b1;
    drive(0, 0, 1, 32'h0C00_0006);
    sb.push_back(tag_word(1, 32'h0C00_0006));
    tick();
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 1, 32'h0D00_0000 + i);
      tick();
    end
    check_eq("sat_m1", o_drop_cnt_24, 4'hE);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h0E00_0000 + i);
      tick();
    end
    drive(0, 0, 0, 0);
    check_eq("sat_ones", o_drop_cnt_24, 4'hF);
    check_eq("sat_ovf", o_overflow, 2'b10);
    i_fifo_full = 1'b0;
    repeat (2) tick();

    // Clear colliding with a drop: drop wins
    i_fifo_full = 1'b1;
    drive(0, 0, 1, 32'h0C00_0007);
    sb.push_back(tag_word(1, 32'h0C00_0007));
    tick();
    drive(0, 0, 1, 32'h0F00_0000);
    i_clear_status = 1'b1;
    tick();
    drive(0, 0, 0, 0);
    i_clear_status = 1'b0;
    check_eq("clrdrop_cnt", o_drop_cnt_24, 1);
    check_eq("clrdrop_ovf", o_overflow, 2'b10);
    i_fifo_full = 1'b0;
    repeat (2) tick();

    // Reset with a buffered word discards it
    i_fifo_full = 1'b1;
    drive(0, 0, 1, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 0, 0);
    i_reset = 1'b1;
    i_mode = 2'b00;
    tick();
    i_reset = 1'b0;
    i_fifo_full = 1'b0;
    check_zero("midrst");
    repeat (3) tick();
    check_eq("midrst_nopush", o_fifo_push, 0);
    check_eq("midrst_idle", o_state, 2'b00);

    check_eq("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
